// File: rtl/fifo_wr_arbiter.sv
// Packet-level round-robin arbiter for the FIFO write port. It can optionally
// write a source-ID header byte ahead of each packet.
module fifo_wr_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_REQ    = 4,
   parameter int ID_WIDTH   = 2,
   parameter bit HDR_EN     = 1'b1
) (
   input  logic                          wr_clk,
   input  logic                          rstn,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          fifo_full,
   input  logic                          fifo_almost_full,
   output logic                          fifo_wr_enb,
   output logic [DATA_WIDTH-1:0]         fifo_wr_data,
   output logic [ID_WIDTH-1:0]           grant_id,
   output logic                          busy,
   output logic [15:0]                   pkt_count
);

   // state   | meaning
   // ST_IDLE | no owner; arbitrate when FIFO has room for at least two words
   // ST_HDR  | write header byte {1, 0.., grant_id}
   // ST_DATA | pass beats from grant_id until its last beat is written
   typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_DATA} state_t;

   localparam int PAD_W = DATA_WIDTH - 1 - ID_WIDTH;

   state_t                r_state, w_state_nxt;
   logic [ID_WIDTH-1:0]   r_grant, w_grant_nxt;
   logic [ID_WIDTH-1:0]   r_last_grant;
   logic [15:0]           r_pkt_count;
   logic                  w_win_found;
   logic [ID_WIDTH-1:0]   w_win_id;
   logic                  w_done;
   logic [DATA_WIDTH-1:0] w_hdr;

   assign w_hdr = {1'b1, {PAD_W{1'b0}}, r_grant};

   // First valid requester strictly after the previous owner, wrapping.
   always_comb begin
      w_win_found = 1'b0;
      w_win_id    = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         if (!w_win_found && req_valid[(int'(r_last_grant) + i) % NUM_REQ]) begin
            w_win_found = 1'b1;
            w_win_id    = ID_WIDTH'((int'(r_last_grant) + i) % NUM_REQ);
         end
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_grant_nxt  = r_grant;
      w_done       = 1'b0;
      fifo_wr_enb  = 1'b0;
      fifo_wr_data = '0;
      req_ready    = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_win_found && !fifo_full && !fifo_almost_full) begin
               w_grant_nxt = w_win_id;
               w_state_nxt = HDR_EN ? ST_HDR : ST_DATA;
            end
         end
         ST_HDR: begin
            fifo_wr_enb  = !fifo_full;
            fifo_wr_data = w_hdr;
            if (!fifo_full) w_state_nxt = ST_DATA;
         end
         ST_DATA: begin
            req_ready[r_grant] = !fifo_full;
            fifo_wr_enb        = req_valid[r_grant] && !fifo_full;
            fifo_wr_data       = req_data[r_grant*DATA_WIDTH +: DATA_WIDTH];
            if (fifo_wr_enb && req_last[r_grant]) begin
               w_done      = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge wr_clk or negedge rstn) begin
      if (!rstn) begin
         r_state      <= ST_IDLE;
         r_grant      <= '0;
         r_last_grant <= ID_WIDTH'(NUM_REQ - 1);
         r_pkt_count  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
         if (w_done) begin
            r_last_grant <= r_grant;
            r_pkt_count  <= r_pkt_count + 16'd1;
         end
      end
   end

   assign grant_id  = r_grant;
   assign busy      = (r_state != ST_IDLE);
   assign pkt_count = r_pkt_count;

endmodule
